// File: rtl/branch_predict_if.sv
// branch_predict_if: IF-stage next-PC generator with direct-mapped BTB and 2-bit counters.
// Optional BTB_STATS_EN adds BrCount/MissCount training statistics outputs.
module branch_predict_if #(
  parameter int BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubbleF,
  input  logic        bubbleE,
  input  logic        BrInstE,
  input  logic        BranchE,
  input  logic        PredictE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  output logic [31:0] PC_IF,
  output logic        PredictF,
  output logic        MispredictE
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
`endif
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IDX;
  logic              valid  [BTB_ENTRIES];
  logic [TW-1:0]     tag    [BTB_ENTRIES];
  logic [31:0]       target [BTB_ENTRIES];
  logic [1:0]        ctr    [BTB_ENTRIES];
  logic [IDX-1:0]    fi, ei;
  logic              fhit, ehit, train;
  logic [31:0]       next_pc;
  assign fi          = PC_IF[IDX+1:2];
  assign ei          = PCE[IDX+1:2];
  assign fhit        = valid[fi] && tag[fi] == PC_IF[31:IDX+2];
  assign ehit        = valid[ei] && tag[ei] == PCE[31:IDX+2];
  assign PredictF    = fhit && ctr[fi][1];
  assign train       = BrInstE && !bubbleE;
  assign MispredictE = train && (BranchE != PredictE);
  always_comb
    next_pc = MispredictE ? (BranchE ? BrTargetE : PCE + 32'd4) :
              PredictF    ? target[fi] : PC_IF + 32'd4;
  // Redirects bypass the fetch stall so a mispredict is never dropped.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      PC_IF <= RESET_PC;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else begin
      if (MispredictE || !bubbleF) PC_IF <= next_pc;
      if (train && ehit) begin
        ctr[ei] <= BranchE ? (ctr[ei] == 2'b11 ? 2'b11 : ctr[ei] + 2'd1)
                           : (ctr[ei] == 2'b00 ? 2'b00 : ctr[ei] - 2'd1);
        if (BranchE) target[ei] <= BrTargetE;
      end else if (train && BranchE) begin
        valid[ei]  <= 1'b1;
        tag[ei]    <= PCE[31:IDX+2];
        target[ei] <= BrTargetE;
        ctr[ei]    <= 2'b10;
      end
    end
`ifdef BTB_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else if (train) begin
      BrCount   <= BrCount + 32'd1;
      MissCount <= MissCount + {31'd0, MispredictE};
    end
`endif
endmodule

// File: tb/tb_branch_predict_if.sv
// tb_branch_predict_if: directed self-checking bench for branch_predict_if.
module tb_branch_predict_if;
  logic        clk = 0, rst = 1;
  logic        bubbleF = 0, bubbleE = 0, BrInstE = 0, BranchE = 0, PredictE = 0;
  logic [31:0] PCE = 0, BrTargetE = 0;
  logic [31:0] PC_IF;
  logic        PredictF, MispredictE;
  int          tests = 0, fails = 0;
`ifdef BTB_STATS_EN
  logic [31:0] BrCount, MissCount;
`endif
  branch_predict_if #(.BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bubbleF(bubbleF), .bubbleE(bubbleE),
    .BrInstE(BrInstE), .BranchE(BranchE), .PredictE(PredictE),
    .PCE(PCE), .BrTargetE(BrTargetE),
    .PC_IF(PC_IF), .PredictF(PredictF), .MispredictE(MispredictE)
`ifdef BTB_STATS_EN
    , .BrCount(BrCount), .MissCount(MissCount)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic br(input logic [31:0] pc, input logic [31:0] tgt, input logic taken, input logic pred);
    BrInstE = 1; PCE = pc; BrTargetE = tgt; BranchE = taken; PredictE = pred;
    #1;
  endtask
  task automatic idle;
    BrInstE = 0; BranchE = 0; PredictE = 0; bubbleE = 0; bubbleF = 0;
    #1;
  endtask
  // Steer fetch to an address via a not-taken mispredict at a never-trained index.
  task automatic goto(input logic [31:0] a);
    br(a - 32'd4, 32'h0, 1'b0, 1'b1);
    chk("goto_misp", {31'd0, MispredictE}, 32'd1);
    tick;
    idle;
    chk("goto_pc", PC_IF, a);
  endtask
  initial begin
    #3;
    chk("rst_pc", PC_IF, 32'h0);
    chk("rst_pf", {31'd0, PredictF}, 32'd0);
    repeat (2) tick;
    rst = 0;
    #1;
    chk("rel_pc0", PC_IF, 32'h0);
    tick; chk("rel_pc4", PC_IF, 32'h4);
    tick; chk("rel_pc8", PC_IF, 32'h8);
    tick; tick; chk("run_pc10", PC_IF, 32'h10);
    rst = 1;
    #1;
    chk("midrst_pc", PC_IF, 32'h0);
    chk("midrst_pf", {31'd0, PredictF}, 32'd0);
    rst = 0;
    #1;
    chk("rel2_pc0", PC_IF, 32'h0);
    tick; chk("rel2_pc4", PC_IF, 32'h4);
    tick; chk("rel2_pc8", PC_IF, 32'h8);
    br(32'h10, 32'h40, 1'b1, 1'b0);
    chk("cold_misp", {31'd0, MispredictE}, 32'd1);
    chk("cold_pf", {31'd0, PredictF}, 32'd0);
    tick;
    idle;
    chk("cold_pc", PC_IF, 32'h40);
    chk("cold_misp_clr", {31'd0, MispredictE}, 32'd0);
`ifdef BTB_STATS_EN
    chk("stat_br", BrCount, 32'd1);
    chk("stat_miss", MissCount, 32'd1);
`endif
    goto(32'h10);
    chk("hit_pf", {31'd0, PredictF}, 32'd1);
    tick;
    chk("hit_target", PC_IF, 32'h40);
    br(32'h10, 32'h40, 1'b1, 1'b1);
    chk("taken_ok_misp", {31'd0, MispredictE}, 32'd0);
    tick; tick;
    idle;
    br(32'h10, 32'h40, 1'b0, 1'b1);
    chk("nt_misp", {31'd0, MispredictE}, 32'd1);
    tick;
    idle;
    chk("nt_redirect", PC_IF, 32'h14);
    goto(32'h10);
    chk("hyst_10_pf", {31'd0, PredictF}, 32'd1);
    br(32'h10, 32'h40, 1'b0, 1'b1);
    chk("prio_misp", {31'd0, MispredictE}, 32'd1);
    tick;
    idle;
    chk("prio_pc", PC_IF, 32'h14);
    goto(32'h10);
    chk("hyst_01_pf", {31'd0, PredictF}, 32'd0);
    br(32'h10, 32'h40, 1'b0, 1'b0);
    chk("nt_agree_misp", {31'd0, MispredictE}, 32'd0);
    tick; tick;
    br(32'h10, 32'h40, 1'b1, 1'b0);
    tick;
    idle;
    chk("sat_redirect", PC_IF, 32'h40);
    goto(32'h10);
    chk("sat_low_pf", {31'd0, PredictF}, 32'd0);
    bubbleF = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_hold", PC_IF, 32'h10);
    end
    br(32'h1C, 32'h0, 1'b0, 1'b1);
    chk("stall_misp", {31'd0, MispredictE}, 32'd1);
    tick;
    chk("stall_redirect", PC_IF, 32'h20);
    idle;
    bubbleE = 1;
    br(32'h20, 32'h80, 1'b1, 1'b0);
    chk("bubbleE_misp", {31'd0, MispredictE}, 32'd0);
    tick;
    idle;
    chk("bubbleE_pc", PC_IF, 32'h24);
    goto(32'h20);
    chk("bubbleE_notrain", {31'd0, PredictF}, 32'd0);
    br(32'h10, 32'h40, 1'b1, 1'b0);
    tick;
    idle;
    goto(32'h50);
    chk("alias_pf", {31'd0, PredictF}, 32'd0);
    tick;
    chk("alias_pc", PC_IF, 32'h54);
    goto(32'h10);
    chk("alias_orig_pf", {31'd0, PredictF}, 32'd1);
    goto(32'hFFFFFFFC);
    chk("wrap_pf", {31'd0, PredictF}, 32'd0);
    tick;
    chk("wrap_pc", PC_IF, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
